// File: rtl/csr_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing port A of the value/column/row CSR RAMs
// between the CSR loader (requester 0) and the SpMV engine (requester 1).
module csr_port_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [1:0]  i_sel0,
    input  logic [1:0]  i_sel1,
    input  logic [13:0] i_addr0,
    input  logic [13:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_rvalid0,
    output logic        o_rvalid1,
    output logic [31:0] o_rdata0,
    output logic [31:0] o_rdata1,
    output logic        o_err0,
    output logic        o_err1,
    output logic [13:0] o_ram_addr,
    output logic [9:0]  o_row_addr,
    output logic [31:0] o_ram_din,
    output logic        o_we_val,
    output logic        o_we_col,
    output logic        o_we_row,
    input  logic [31:0] i_dout_val,
    input  logic [31:0] i_dout_col,
    input  logic [31:0] i_dout_row
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t               r_state;
    logic                 r_lastOwner;
    logic [CNT_W-1:0]     r_beatCnt;
    logic                 r_gnt0;
    logic                 r_gnt1;
    logic [13:0]          r_holdAddr;
    logic [31:0]          r_holdDin;
    logic                 r_err0;
    logic                 r_err1;
    logic [RD_LAT-1:0]    r_pValid;
    logic [RD_LAT-1:0]    r_pOwner;
    logic [RD_LAT-1:0]    r_pIll;
    logic [RD_LAT-1:0][1:0] r_pSel;

    logic        w_beat0;
    logic        w_beat1;
    logic        w_beat;
    logic        w_ownReq;
    logic        w_othReq;
    logic        w_we;
    logic [1:0]  w_sel;
    logic [13:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_illegal;
    logic        w_write;
    logic        w_read;
    logic        w_retValid;
    logic        w_retOwner;
    logic [31:0] w_retData;

    assign w_beat0  = r_gnt0 & i_req0;
    assign w_beat1  = r_gnt1 & i_req1;
    assign w_beat   = w_beat0 | w_beat1;
    assign w_ownReq = r_gnt1 ? i_req1 : i_req0;
    assign w_othReq = r_gnt1 ? i_req0 : i_req1;

    assign w_we    = r_gnt1 ? i_we1    : i_we0;
    assign w_sel   = r_gnt1 ? i_sel1   : i_sel0;
    assign w_addr  = r_gnt1 ? i_addr1  : i_addr0;
    assign w_wdata = r_gnt1 ? i_wdata1 : i_wdata0;

    // The row RAM is only 1K deep, so any row access above it is treated like sel==3.
    assign w_illegal = (w_sel == 2'd3) || ((w_sel == 2'd2) && (w_addr[13:10] != 4'd0));
    assign w_write   = w_beat & w_we & ~w_illegal;
    assign w_read    = w_beat & ~w_we;

    assign o_we_val   = w_write & (w_sel == 2'd0);
    assign o_we_col   = w_write & (w_sel == 2'd1);
    assign o_we_row   = w_write & (w_sel == 2'd2);
    assign o_ram_addr = w_beat ? w_addr  : r_holdAddr;
    assign o_ram_din  = w_beat ? w_wdata : r_holdDin;
    assign o_row_addr = o_ram_addr[9:0];

    assign o_gnt0 = r_gnt0;
    assign o_gnt1 = r_gnt1;
    assign o_err0 = r_err0;
    assign o_err1 = r_err1;

    // Ownership FSM: the grant flops are the Moore outputs of the state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_lastOwner <= 1'b1;
            r_beatCnt   <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beatCnt <= '0;
                    if (i_req0 && (!i_req1 || r_lastOwner)) begin
                        r_state     <= OWN0;
                        r_gnt0      <= 1'b1;
                        r_lastOwner <= 1'b0;
                    end else if (i_req1) begin
                        r_state     <= OWN1;
                        r_gnt1      <= 1'b1;
                        r_lastOwner <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (!w_ownReq || ((r_beatCnt == CNT_MAX) && w_othReq)) begin
                        r_beatCnt <= '0;
                        if (w_othReq) begin
                            r_state     <= r_gnt1 ? OWN0 : OWN1;
                            r_gnt0      <= r_gnt1;
                            r_gnt1      <= ~r_gnt1;
                            r_lastOwner <= ~r_gnt1;
                        end else begin
                            r_state <= IDLE;
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                        end
                    end else if (r_beatCnt != CNT_MAX) begin
                        r_beatCnt <= r_beatCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return pipe tracks who issued each read so returns survive ownership switches.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_holdAddr <= '0;
            r_holdDin  <= '0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_pValid   <= '0;
            r_pOwner   <= '0;
            r_pIll     <= '0;
            r_pSel     <= '0;
        end else begin
            if (w_beat) begin
                r_holdAddr <= w_addr;
                r_holdDin  <= w_wdata;
            end
            r_err0      <= w_beat0 & w_illegal;
            r_err1      <= w_beat1 & w_illegal;
            r_pValid[0] <= w_read;
            r_pOwner[0] <= r_gnt1;
            r_pIll[0]   <= w_illegal;
            r_pSel[0]   <= w_sel;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pValid[i] <= r_pValid[i-1];
                r_pOwner[i] <= r_pOwner[i-1];
                r_pIll[i]   <= r_pIll[i-1];
                r_pSel[i]   <= r_pSel[i-1];
            end
        end
    end

    assign w_retValid = r_pValid[RD_LAT-1];
    assign w_retOwner = r_pOwner[RD_LAT-1];

    always_comb begin
        w_retData = '0;
        if (!r_pIll[RD_LAT-1]) begin
            case (r_pSel[RD_LAT-1])
                2'd0:    w_retData = i_dout_val;
                2'd1:    w_retData = i_dout_col;
                2'd2:    w_retData = i_dout_row;
                default: w_retData = '0;
            endcase
        end
    end

    assign o_rvalid0 = w_retValid & ~w_retOwner;
    assign o_rvalid1 = w_retValid & w_retOwner;
    assign o_rdata0  = o_rvalid0 ? w_retData : '0;
    assign o_rdata1  = o_rvalid1 ? w_retData : '0;

endmodule
